// File: rtl/multicycle_control_fsm_if.sv
// -----------------------------------------------------------------------------
// multicycle_control_fsm_if
// Bundle between the multi-cycle control sequencer and the RV32I datapath.
//   master : sequencer side (reads op/zero/mem_ready, drives every control)
//   slave  : datapath/memory side (drives op/zero/mem_ready, reads controls)
// Inputs to sequencer : op[6:0] (IR opcode), zero (ALU flag), mem_ready
// Outputs             : mem_req, mem_write, adr_src, ir_write, pc_write,
//                       alu_src_a, alu_src_b, alu_op, imm_src, result_src,
//                       reg_write, fault, fault_cause, state, instr_retired
// -----------------------------------------------------------------------------
interface multicycle_control_fsm_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       op;
  logic             zero;
  logic             mem_ready;
  logic             mem_req;
  logic             mem_write;
  logic             adr_src;
  logic             ir_write;
  logic             pc_write;
  logic [1:0]       alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic [1:0]       imm_src;
  logic [1:0]       result_src;
  logic             reg_write;
  logic             fault;
  logic [1:0]       fault_cause;
  logic [3:0]       state;
  logic [CNT_W-1:0] instr_retired;

  modport master (
    input  op, zero, mem_ready,
    output mem_req, mem_write, adr_src, ir_write, pc_write,
           alu_src_a, alu_src_b, alu_op, imm_src, result_src,
           reg_write, fault, fault_cause, state, instr_retired
  );

  modport slave (
    output op, zero, mem_ready,
    input  mem_req, mem_write, adr_src, ir_write, pc_write,
           alu_src_a, alu_src_b, alu_op, imm_src, result_src,
           reg_write, fault, fault_cause, state, instr_retired
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_control_fsm
// Moore control sequencer for the multi-cycle RV32I core. Steps each
// instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK, traps on an
// illegal opcode or on memory that stalls too long, and counts retired
// instructions.
// Ports:
//   clk   : core clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : multicycle_control_fsm_if.master (opcode/flags in, controls out)
// Parameters:
//   WAIT_LIMIT : max consecutive mem_ready-low cycles in a memory state
//   CNT_W      : width of the retired-instruction counter
// -----------------------------------------------------------------------------
module multicycle_control_fsm #(
  parameter int WAIT_LIMIT = 15,
  parameter int CNT_W      = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  multicycle_control_fsm_if.master bus
);

  localparam int WCNT_W = $clog2(WAIT_LIMIT + 1);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    TRAP     = 4'd10
  } state_t;

  state_t            state_r;
  state_t            next_state_s;
  logic [WCNT_W-1:0] wait_cnt_r;
  logic [CNT_W-1:0]  retired_r;
  logic              fault_r;
  logic [1:0]        cause_r;
  logic [1:0]        cause_s;
  logic              retire_s;
  logic              timeout_s;
  logic              wait_state_s;

  // Timeout fires only on the limit cycle with memory still not ready.
  assign timeout_s    = (wait_cnt_r == WCNT_W'(WAIT_LIMIT)) && !bus.mem_ready;
  assign wait_state_s = (state_r == FETCH) || (state_r == MEMREAD) || (state_r == MEMWRITE);

  // Next-state and Moore control decode; every output defaults to 0.
  always_comb begin
    next_state_s   = FETCH;
    cause_s        = 2'b00;
    retire_s       = 1'b0;
    bus.mem_req    = 1'b0;
    bus.mem_write  = 1'b0;
    bus.adr_src    = 1'b0;
    bus.ir_write   = 1'b0;
    bus.pc_write   = 1'b0;
    bus.alu_src_a  = 2'b00;
    bus.alu_src_b  = 2'b00;
    bus.alu_op     = 2'b00;
    bus.imm_src    = 2'b00;
    bus.result_src = 2'b00;
    bus.reg_write  = 1'b0;
    case (state_r)
      FETCH: begin
        bus.mem_req   = 1'b1;
        bus.alu_src_b = 2'b10;
        // mem_ready on the limit cycle completes the fetch instead of trapping.
        if (bus.mem_ready) begin
          bus.ir_write   = 1'b1;
          bus.pc_write   = 1'b1;
          bus.result_src = 2'b10;
          next_state_s   = DECODE;
        end else if (timeout_s) begin
          next_state_s = TRAP;
          cause_s      = 2'b10;
        end else begin
          next_state_s = FETCH;
        end
      end
      DECODE: begin
        // Branch target PC+imm is precomputed here into ALUOut.
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b01;
        bus.imm_src   = 2'b10;
        case (bus.op)
          OP_LOAD, OP_STORE: next_state_s = MEMADR;
          OP_RTYPE:          next_state_s = EXECR;
          OP_ITYPE:          next_state_s = EXECI;
          OP_BEQ:            next_state_s = BEQ;
          default: begin
            next_state_s = TRAP;
            cause_s      = 2'b01;
          end
        endcase
      end
      MEMADR: begin
        bus.alu_src_a = 2'b10;
        bus.alu_src_b = 2'b01;
        if (bus.op == OP_LOAD) begin
          bus.imm_src  = 2'b00;
          next_state_s = MEMREAD;
        end else begin
          bus.imm_src  = 2'b01;
          next_state_s = MEMWRITE;
        end
      end
      MEMREAD: begin
        bus.mem_req = 1'b1;
        bus.adr_src = 1'b1;
        if (bus.mem_ready) begin
          next_state_s = MEMWB;
        end else if (timeout_s) begin
          next_state_s = TRAP;
          cause_s      = 2'b10;
        end else begin
          next_state_s = MEMREAD;
        end
      end
      MEMWB: begin
        bus.result_src = 2'b01;
        bus.reg_write  = 1'b1;
        next_state_s   = FETCH;
        retire_s       = 1'b1;
      end
      MEMWRITE: begin
        bus.mem_req   = 1'b1;
        bus.mem_write = 1'b1;
        bus.adr_src   = 1'b1;
        if (bus.mem_ready) begin
          next_state_s = FETCH;
          retire_s     = 1'b1;
        end else if (timeout_s) begin
          next_state_s = TRAP;
          cause_s      = 2'b10;
        end else begin
          next_state_s = MEMWRITE;
        end
      end
      EXECR: begin
        bus.alu_src_a = 2'b10;
        bus.alu_src_b = 2'b00;
        bus.alu_op    = 2'b10;
        next_state_s  = ALUWB;
      end
      EXECI: begin
        bus.alu_src_a = 2'b10;
        bus.alu_src_b = 2'b01;
        bus.imm_src   = 2'b00;
        bus.alu_op    = 2'b10;
        next_state_s  = ALUWB;
      end
      ALUWB: begin
        bus.result_src = 2'b00;
        bus.reg_write  = 1'b1;
        next_state_s   = FETCH;
        retire_s       = 1'b1;
      end
      BEQ: begin
        bus.alu_src_a  = 2'b10;
        bus.alu_src_b  = 2'b00;
        bus.alu_op     = 2'b01;
        bus.result_src = 2'b00;
        bus.pc_write   = bus.zero;
        next_state_s   = FETCH;
        retire_s       = 1'b1;
      end
      TRAP: begin
        next_state_s = TRAP;
      end
      default: begin
        // Unused encodings recover to FETCH with all controls low.
        next_state_s = FETCH;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Memory-wait counter: cleared on any state change, saturates at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_r <= {WCNT_W{1'b0}};
    end else if (next_state_s != state_r) begin
      wait_cnt_r <= {WCNT_W{1'b0}};
    end else if (wait_state_s && !bus.mem_ready && (wait_cnt_r != WCNT_W'(WAIT_LIMIT))) begin
      wait_cnt_r <= wait_cnt_r + WCNT_W'(1'b1);
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_r <= {CNT_W{1'b0}};
    end else if (retire_s) begin
      retired_r <= retired_r + CNT_W'(1'b1);
    end else begin
      retired_r <= retired_r;
    end
  end

  // Sticky fault flag and cause, captured on entry into TRAP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_r <= 1'b0;
      cause_r <= 2'b00;
    end else if ((state_r != TRAP) && (next_state_s == TRAP)) begin
      fault_r <= 1'b1;
      cause_r <= cause_s;
    end else begin
      fault_r <= fault_r;
      cause_r <= cause_r;
    end
  end

  assign bus.state         = state_r;
  assign bus.fault         = fault_r;
  assign bus.fault_cause   = cause_r;
  assign bus.instr_retired = retired_r;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control_fsm
// Directed bench for the multi-cycle control sequencer. Each instruction is
// expanded into the list of states it must visit (from its class and the
// memory wait pattern); a per-cycle compare process checks state and every
// control output against the expected control table, plus model counters for
// retired instructions and the fault indication.
// -----------------------------------------------------------------------------
module tb_multicycle_control_fsm;

  localparam int WL = 15;
  localparam int CW = 32;

  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] ST  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] JAL = 7'b1101111;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  multicycle_control_fsm_if #(.CNT_W(CW)) bus ();

  multicycle_control_fsm #(.WAIT_LIMIT(WL), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] aluop;
    logic [1:0] imm;
    logic [1:0] res;
    logic       reg_write;
  } ctrl_t;

  int          checks   = 0;
  int          failures = 0;
  logic        chk_en   = 1'b0;
  int          exp_state = 0;
  logic        mdl_fault = 1'b0;
  logic [1:0]  mdl_cause = 2'b00;
  logic [31:0] mdl_retired = 32'd0;
  ctrl_t       exp_c;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Control table: what each step of the instruction sequence must present.
  function automatic ctrl_t expect_ctrl(input int st, input logic [6:0] op,
                                        input logic z, input logic mr);
    ctrl_t c;
    c = '0;
    case (st)
      0: begin
        c.mem_req = 1'b1; c.b = 2'b10;
        if (mr) begin c.ir_write = 1'b1; c.pc_write = 1'b1; c.res = 2'b10; end
      end
      1: begin c.a = 2'b01; c.b = 2'b01; c.imm = 2'b10; end
      2: begin c.a = 2'b10; c.b = 2'b01; c.imm = (op == LD) ? 2'b00 : 2'b01; end
      3: begin c.mem_req = 1'b1; c.adr_src = 1'b1; end
      4: begin c.res = 2'b01; c.reg_write = 1'b1; end
      5: begin c.mem_req = 1'b1; c.mem_write = 1'b1; c.adr_src = 1'b1; end
      6: begin c.a = 2'b10; c.b = 2'b00; c.aluop = 2'b10; end
      7: begin c.a = 2'b10; c.b = 2'b01; c.aluop = 2'b10; end
      8: begin c.reg_write = 1'b1; end
      9: begin c.a = 2'b10; c.aluop = 2'b01; c.pc_write = z; end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      exp_c = expect_ctrl(exp_state, bus.op, bus.zero, bus.mem_ready);
      chk("state",       32'(bus.state),         32'(exp_state));
      chk("mem_req",     32'(bus.mem_req),       32'(exp_c.mem_req));
      chk("mem_write",   32'(bus.mem_write),     32'(exp_c.mem_write));
      chk("adr_src",     32'(bus.adr_src),       32'(exp_c.adr_src));
      chk("ir_write",    32'(bus.ir_write),      32'(exp_c.ir_write));
      chk("pc_write",    32'(bus.pc_write),      32'(exp_c.pc_write));
      chk("alu_src_a",   32'(bus.alu_src_a),     32'(exp_c.a));
      chk("alu_src_b",   32'(bus.alu_src_b),     32'(exp_c.b));
      chk("alu_op",      32'(bus.alu_op),        32'(exp_c.aluop));
      chk("imm_src",     32'(bus.imm_src),       32'(exp_c.imm));
      chk("result_src",  32'(bus.result_src),    32'(exp_c.res));
      chk("reg_write",   32'(bus.reg_write),     32'(exp_c.reg_write));
      chk("fault",       32'(bus.fault),         32'(mdl_fault));
      chk("fault_cause", 32'(bus.fault_cause),   32'(mdl_cause));
      chk("retired",     bus.instr_retired,      mdl_retired);
    end
  end

  // One cycle: drive mem_ready, name the state the DUT must be in now.
  task automatic step(input int st, input logic mr);
    bus.mem_ready = mr;
    exp_state     = st;
    chk_en        = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.mem_ready = 1'b0;
    mdl_fault     = 1'b0;
    mdl_cause     = 2'b00;
    mdl_retired   = 32'd0;
    exp_state     = 0;
    chk_en        = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Expand one instruction into its expected state sequence.
  task automatic do_instr(input logic [6:0] op, input logic z, input int fw, input int mw);
    logic trapped;
    trapped  = 1'b0;
    bus.op   = op;
    bus.zero = z;
    for (int i = 0; i < fw; i++) step(0, 1'b0);
    step(0, 1'b1);
    step(1, 1'b0);
    case (op)
      LD: begin
        step(2, 1'b0);
        for (int i = 0; i < mw; i++) step(3, 1'b0);
        step(3, 1'b1);
        step(4, 1'b0);
      end
      ST: begin
        step(2, 1'b0);
        for (int i = 0; i < mw; i++) step(5, 1'b0);
        step(5, 1'b1);
      end
      RT: begin step(6, 1'b0); step(8, 1'b0); end
      IT: begin step(7, 1'b0); step(8, 1'b0); end
      BQ: begin step(9, 1'b0); end
      default: begin
        trapped   = 1'b1;
        mdl_fault = 1'b1;
        mdl_cause = 2'b01;
        for (int i = 0; i < 20; i++) step(10, 1'b1);
      end
    endcase
    if (!trapped) mdl_retired = mdl_retired + 32'd1;
  endtask

  initial begin
    bus.op        = RT;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b0;
    do_reset();

    do_instr(RT, 1'b0, 0, 0);
    chk("lit_retired_after_r", bus.instr_retired, 32'd1);
    do_instr(LD, 1'b0, 0, 3);
    do_instr(ST, 1'b0, 1, 2);
    do_instr(IT, 1'b0, 0, 0);
    do_instr(BQ, 1'b1, 0, 0);
    do_instr(BQ, 1'b0, 0, 0);
    chk("lit_retired_after_six", bus.instr_retired, 32'd6);
    // Long waits in both FETCH and MEMREAD: counter must clear between them.
    do_instr(LD, 1'b0, WL, WL);
    // mem_ready exactly on the limit cycle wins over the timeout.
    do_instr(RT, 1'b0, WL, 0);
    chk("lit_no_fault", 32'(bus.fault), 32'd0);
    chk("lit_retired_eight", bus.instr_retired, 32'd8);

    do_instr(JAL, 1'b0, 0, 0);
    chk("lit_illegal_fault", 32'(bus.fault), 32'd1);
    chk("lit_illegal_cause", 32'(bus.fault_cause), 32'd1);
    chk("lit_trap_state", 32'(bus.state), 32'd10);
    chk("lit_trap_retired", bus.instr_retired, 32'd8);

    do_reset();
    chk("lit_rst_state", 32'(bus.state), 32'd0);
    chk("lit_rst_fault", 32'(bus.fault), 32'd0);

    // Fetch timeout: WL+1 low cycles in FETCH, then TRAP.
    bus.op = RT;
    for (int i = 0; i < WL + 1; i++) step(0, 1'b0);
    mdl_fault = 1'b1;
    mdl_cause = 2'b10;
    for (int i = 0; i < 5; i++) step(10, 1'b1);
    chk("lit_timeout_cause", 32'(bus.fault_cause), 32'd2);

    // Reset in the middle of a store: controls return to FETCH values.
    do_reset();
    bus.op = ST;
    step(0, 1'b1);
    step(1, 1'b0);
    step(2, 1'b0);
    step(5, 1'b0);
    do_reset();
    chk("lit_midrst_memwrite", 32'(bus.mem_write), 32'd0);
    do_instr(RT, 1'b0, 0, 0);
    chk("lit_retired_after_rst", bus.instr_retired, 32'd1);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
